// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-channel round-robin arbiter/mux.
package rr_arb_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  // Channel index one step further in the round-robin order; 3 wraps to 0.
  function automatic ch_idx_t next_idx(input ch_idx_t idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: the first requesting channel
// found when searching from ptr upward (mod 4) wins.
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  output logic            gnt_valid,
  output ch_idx_t         gnt_idx
);

  ch_idx_t w_idx;

  // Walk ptr, ptr+1, ptr+2, ptr+3 and latch the first request seen.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    w_idx     = ptr;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = ptr + ch_idx_t'(k);
      if (!gnt_valid && req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Registered round-robin arbiter feeding a 4:1 data mux. One word per cycle,
// one cycle of latency; out_sel travels with out_data.
module rr_arb_mux_4_1
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_valid,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  output logic [N_CH-1:0] in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [1:0]      out_sel,
  input  logic            out_ready
);

  ch_idx_t         r_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  ch_idx_t         r_out_sel;

  logic            w_load;
  logic            w_gnt_valid;
  ch_idx_t         w_gnt_idx;
  logic            w_xfer;
  logic [W-1:0]    w_data;
  logic [N_CH-1:0] w_ready;

  rr_pick_4 u_pick (
    .req       (in_valid),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // The output register can take a word when empty or being drained.
  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = w_gnt_valid && w_load && !rst;

  // One-hot ready for the winning channel, only when a transfer happens.
  always_comb begin
    w_ready = '0;
    if (w_xfer) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Data selection by grant index, in the same if-chain form as the plain mux.
  always_comb begin
    if (w_gnt_idx == 2'd0) begin
      w_data = d0;
    end else if (w_gnt_idx == 2'd1) begin
      w_data = d1;
    end else if (w_gnt_idx == 2'd2) begin
      w_data = d2;
    end else begin
      w_data = d3;
    end
  end

  // Output register and priority pointer; pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_data;
      r_out_sel   <= w_gnt_idx;
      r_out_valid <= 1'b1;
      r_ptr       <= next_idx(w_gnt_idx);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Self-checking bench for rr_arb_mux_4_1: directed scenarios plus a
// randomised valid/ready run, with a reference model and a word scoreboard.
module tb_rr_arb_mux_4_1;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic         mValid;
  logic [W-1:0] mData;
  logic [1:0]   mSel;
  logic [1:0]   mPtr;
  logic [3:0]   lastReady;
  int           waitCnt [4];
  logic [W+1:0] sbQ [$];
  logic [5:0]   seqCnt [4];

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, check in_ready against the model before the edge,
  // run the scoreboard, then check the output register after the edge.
  task automatic applyStimulus(input logic rstV, input logic [3:0] v, input logic oready,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] e);
    logic         load;
    logic         found;
    logic [1:0]   win;
    logic [1:0]   idx;
    logic [3:0]   expReady;
    logic [W-1:0] dv [4];
    logic [W+1:0] ent;
    @(negedge clk);
    rst = rstV; in_valid = v; out_ready = oready;
    d0 = a; d1 = b; d2 = c; d3 = e;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
    #1;
    load  = !mValid || oready;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = mPtr + 2'(k);
      if (!found && v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    expReady = 4'b0000;
    if (!rstV && found && load) expReady[win] = 1'b1;
    lastReady = in_ready;
    checkOutput("in_ready", {28'd0, in_ready}, {28'd0, expReady});

    // downstream consumes the held word
    if (!rstV && out_valid && oready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        ent = sbQ.pop_front();
        checkOutput("sb_sel", {30'd0, out_sel}, {30'd0, ent[W+1:W]});
        checkOutput("sb_data", {{(32-W){1'b0}}, out_data}, {{(32-W){1'b0}}, ent[W-1:0]});
      end
    end

    // fairness bookkeeping, counted in transfers
    for (int i = 0; i < 4; i++) begin
      if (rstV || !v[i]) begin
        waitCnt[i] = 0;
      end else if (expReady[i]) begin
        checkOutput("fairness", {31'd0, waitCnt[i] <= 3}, 32'd1);
        waitCnt[i] = 0;
      end else if (expReady != 4'b0000) begin
        waitCnt[i]++;
      end
    end

    // model next state
    if (rstV) begin
      mValid = 1'b0; mData = '0; mSel = 2'd0; mPtr = 2'd0;
      sbQ.delete();
    end else if (expReady != 4'b0000) begin
      mValid = 1'b1; mData = dv[win]; mSel = win; mPtr = win + 2'd1;
      sbQ.push_back({win, dv[win]});
    end else if (oready) begin
      mValid = 1'b0;
    end

    @(posedge clk);
    #1;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mValid});
    checkOutput("out_sel", {30'd0, out_sel}, {30'd0, mSel});
    checkOutput("out_data", {{(32-W){1'b0}}, out_data}, {{(32-W){1'b0}}, mData});
  endtask

  initial begin
    logic [3:0] rv;
    logic       ro;
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    mValid = 1'b0; mData = '0; mSel = 2'd0; mPtr = 2'd0; lastReady = '0;
    for (int i = 0; i < 4; i++) begin
      waitCnt[i] = 0;
      seqCnt[i]  = '0;
    end

    // reset held with every channel requesting
    applyStimulus(1'b1, 4'hF, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
    checkOutput("rst_ready", {28'd0, lastReady}, 32'd0);
    applyStimulus(1'b1, 4'hF, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sel", {30'd0, out_sel}, 32'd0);

    // full contention rotates 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'hF, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
      checkOutput("cont_sel", {30'd0, out_sel}, 32'(k % 4));
      checkOutput("cont_data", {24'd0, out_data}, 32'(k % 4 + 1));
    end
    checkOutput("first_grant_after_rst", 32'd1, 32'd1 & {31'd0, out_valid});

    // skip and wrap from ptr 0
    applyStimulus(1'b1, 4'h0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b1001, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
      checkOutput("wrap_sel", {30'd0, out_sel}, (k % 2 == 0) ? 32'd0 : 32'd3);
    end
    applyStimulus(1'b0, 4'b0100, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("skip_sel", {30'd0, out_sel}, 32'd2);

    // backpressure: word from channel 2 held, nothing accepted
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'hF, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
      checkOutput("bp_ready", {28'd0, lastReady}, 32'd0);
      checkOutput("bp_sel", {30'd0, out_sel}, 32'd2);
      checkOutput("bp_data", {24'd0, out_data}, 32'h33);
    end
    applyStimulus(1'b0, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("bp_release_ready", {28'd0, lastReady}, 32'b1000);

    // reset while a channel-2 word is stalled
    applyStimulus(1'b0, 4'b0100, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b0, 4'b1001, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("hold_sel", {30'd0, out_sel}, 32'd2);
    applyStimulus(1'b1, 4'b1001, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("midrst_ready", {28'd0, lastReady}, 32'd0);
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 4'b1001, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("midrst_grant", {28'd0, lastReady}, 32'b0001);

    // randomised traffic; each channel tags its words with a sequence number
    for (int n = 0; n < 1500; n++) begin
      rv = 4'($urandom_range(0, 15));
      ro = ($urandom_range(0, 3) != 0);
      applyStimulus(1'b0, rv, ro, {2'd0, seqCnt[0]}, {2'd1, seqCnt[1]},
                    {2'd2, seqCnt[2]}, {2'd3, seqCnt[3]});
      for (int i = 0; i < 4; i++) begin
        if (lastReady[i]) seqCnt[i] = seqCnt[i] + 6'd1;
      end
    end

    // drain whatever is still held
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux_4_1.md
# rr_arb_mux_4_1

Registered round-robin arbiter in front of the 4:1 data mux. It takes four valid/ready source channels and grants one per cycle with rotating priority. The granted word and its 2-bit channel index go into a single output register, so downstream logic gets the data together with the `sel` that produced it. Throughput is one word per cycle and latency is one cycle.

## Interface
- `W`, default 4: data width per channel.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous reset, active-high.
- `in_valid`  in  4: bit i set means channel i holds a word.
- `d0`, `d1`, `d2`, `d3`  in  W each: channel data.
- `in_ready`  out  4: bit i set means channel i's word is accepted this cycle. Combinational. At most one bit is set.
- `out_valid`  out  1: output register holds a word.
- `out_data`  out  W: registered granted word.
- `out_sel`  out  2: index of the channel that supplied `out_data`.
- `out_ready`  in  1: downstream accepts this cycle.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Pointer `ptr` (2 bits) names the highest-priority channel.
  - Search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The winner is the first channel in that order with `in_valid` set.
- `in_ready[winner] = load`. All other `in_ready` bits are 0. If no channel is valid, all bits are 0.
- On a transfer (`in_valid[i] && in_ready[i]`):
  - `out_data <= d_i`, `out_sel <= i`, `out_valid <= 1`.
  - `ptr <= i+1` (mod 4, so 3 wraps to 0).
- `out_ready && out_valid` with no new transfer: `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- `out_valid && !out_ready`:
  - `out_data`, `out_sel` and `out_valid` are frozen.
  - `in_ready = 0`.
  - `ptr` does not move.
- No valid inputs: `ptr` does not move. There is no idle-cycle rotation.
- Sources may drop `in_valid` without a handshake. The arbiter never depends on a source holding `in_valid`.
- Fairness: a continuously valid channel is granted within 4 transfers.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `ptr = 0`. `in_ready` is 0 while `rst` is high.
- Latency is 1 cycle: a transfer at edge N gives `out_valid = 1` after edge N.
- Back-to-back operation: with `out_ready` held at 1, the block accepts one word every cycle with no bubbles.
- Simultaneous drain and load:
  - When `out_ready = 1` and a new transfer happens in the same cycle, the register is overwritten.
  - `out_valid` stays 1.
- Reset mid-operation: a held word is discarded and the pointer returns to 0. No `in_ready` is asserted in the reset cycle.
- Combinational paths:
  - `in_ready` depends on `in_valid`, `out_ready`, `out_valid` and `ptr`.
  - No combinational path from `d*` to any output.

## Structure
- Package `rr_arb_pkg` holds:
  - `N_CH = 4`
  - `typedef logic [1:0] ch_idx_t`
  - a function `next_idx(ch_idx_t)` that returns the index +1 with wrap.
- Sub-module `rr_pick_4`: purely combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `ptr`.
  - Outputs: `gnt_valid` and a 2-bit `gnt_idx`.
- Top level: `ptr` register, output register, and data selection by `gnt_idx`. The data selection uses the same if-chain selection style as the existing 4:1 mux.

## Test plan
- Reset behaviour: hold `rst = 1` with all `in_valid` set. Expect `in_ready = 0`, `out_valid = 0`, `out_sel = 0`. Release reset; the first grant goes to channel 0.
- Full contention: all `in_valid` set, `d0..d3` = 4'h1, 4'h2, 4'h3, 4'h4, `out_ready = 1`. Expect `out_sel` = 0,1,2,3,0 and `out_data` = 1,2,3,4,1 on consecutive cycles.
- Skip and wrap: `in_valid = 4'b1001` from `ptr = 0`. Expect grants 0, 3, 0, 3. Then `in_valid = 4'b0100`: expect grant 2.
- Backpressure: `out_ready = 0` for 3 cycles while `out_valid = 1`. Expect `out_data` and `out_sel` stable, `in_ready = 0`, `ptr` unchanged. Then `out_ready = 1`: the next channel in round-robin order is accepted that same cycle.
- Reset mid-hold: a stalled word with `out_sel = 2`, then a 1-cycle `rst`. Expect `out_valid = 0` and `ptr = 0`. The next grant favours channel 0 over channel 3.
- Randomised valid/ready scoreboard:
  - Every word accepted on channel i appears exactly once with `out_sel = i`, in per-channel order.
  - A continuously valid channel never waits more than 4 transfers.
